// File: rtl/myip_pwm_axil_slave.sv
// myip_pwm_axil_slave: AXI4-Lite 4-register slave driving a prescaled PWM output (optional irq via MYIP_PWM_IRQ_EN)
module myip_pwm_axil_slave #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4,
  parameter int CNT_WIDTH          = 16
) (
  input  logic                              S_AXI_ACLK,
  input  logic                              S_AXI_ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
  input  logic [2:0]                        S_AXI_AWPROT,
  input  logic                              S_AXI_AWVALID,
  output logic                              S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
  input  logic                              S_AXI_WVALID,
  output logic                              S_AXI_WREADY,
  output logic [1:0]                        S_AXI_BRESP,
  output logic                              S_AXI_BVALID,
  input  logic                              S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
  input  logic [2:0]                        S_AXI_ARPROT,
  input  logic                              S_AXI_ARVALID,
  output logic                              S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
  output logic [1:0]                        S_AXI_RRESP,
  output logic                              S_AXI_RVALID,
  input  logic                              S_AXI_RREADY,
  output logic                              pwm_out
`ifdef MYIP_PWM_IRQ_EN
  ,
  output logic                              irq
`endif
);
  logic [3:0][C_S_AXI_DATA_WIDTH-1:0] regs_q, regs_d;
  logic                 wr_en, rd_en, en, tick, wrap;
  logic [CNT_WIDTH-1:0] psc_q, cnt_q, period_sh, duty_sh;
  logic                 unused;
  assign unused      = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};
  assign S_AXI_BRESP = 2'b00;
  assign S_AXI_RRESP = 2'b00;
  assign wr_en       = S_AXI_AWREADY && S_AXI_AWVALID && S_AXI_WVALID;
  assign rd_en       = S_AXI_ARREADY && S_AXI_ARVALID;
  assign en          = regs_q[0][0];
  assign tick        = en && (psc_q == regs_q[3][CNT_WIDTH-1:0]);
  assign wrap        = tick && (cnt_q == period_sh);
  // next register contents: byte-masked merge of the accepted write
  always_comb begin
    regs_d = regs_q;
    for (int r = 0; r < 4; r++)
      for (int b = 0; b < C_S_AXI_DATA_WIDTH/8; b++)
        if (wr_en && S_AXI_AWADDR[3:2] == 2'(r) && S_AXI_WSTRB[b])
          regs_d[r][8*b +: 8] = S_AXI_WDATA[8*b +: 8];
  end
  // AXI handshakes, register file and read data; reads see same-edge writes via regs_d
  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN) begin
      regs_q        <= '0;
      S_AXI_AWREADY <= 1'b0;
      S_AXI_WREADY  <= 1'b0;
      S_AXI_BVALID  <= 1'b0;
      S_AXI_ARREADY <= 1'b0;
      S_AXI_RVALID  <= 1'b0;
      S_AXI_RDATA   <= '0;
    end else begin
      regs_q        <= regs_d;
      S_AXI_AWREADY <= S_AXI_AWVALID && S_AXI_WVALID && !S_AXI_BVALID && !S_AXI_AWREADY;
      S_AXI_WREADY  <= S_AXI_AWVALID && S_AXI_WVALID && !S_AXI_BVALID && !S_AXI_AWREADY;
      S_AXI_BVALID  <= wr_en ? 1'b1 : (S_AXI_BREADY ? 1'b0 : S_AXI_BVALID);
      S_AXI_ARREADY <= S_AXI_ARVALID && !S_AXI_RVALID && !S_AXI_ARREADY;
      S_AXI_RVALID  <= rd_en ? 1'b1 : (S_AXI_RREADY ? 1'b0 : S_AXI_RVALID);
      if (rd_en) S_AXI_RDATA <= regs_d[S_AXI_ARADDR[3:2]];
    end
  end
  // PWM engine: shadows track the registers while disabled and reload only at wrap while running
  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN) begin
      psc_q     <= '0;
      cnt_q     <= '0;
      period_sh <= '0;
      duty_sh   <= '0;
      pwm_out   <= 1'b0;
`ifdef MYIP_PWM_IRQ_EN
      irq       <= 1'b0;
`endif
    end else if (!en) begin
      psc_q     <= '0;
      cnt_q     <= '0;
      period_sh <= regs_q[1][CNT_WIDTH-1:0];
      duty_sh   <= regs_q[2][CNT_WIDTH-1:0];
      pwm_out   <= 1'b0;
`ifdef MYIP_PWM_IRQ_EN
      irq       <= 1'b0;
`endif
    end else begin
      psc_q   <= tick ? '0 : psc_q + CNT_WIDTH'(1);
      pwm_out <= cnt_q < duty_sh;
      if (tick) cnt_q <= wrap ? '0 : cnt_q + CNT_WIDTH'(1);
      if (wrap) period_sh <= regs_q[1][CNT_WIDTH-1:0];
      if (wrap) duty_sh <= regs_q[2][CNT_WIDTH-1:0];
`ifdef MYIP_PWM_IRQ_EN
      irq     <= wrap && regs_q[0][1];
`endif
    end
  end
endmodule

// File: tb/tb_myip_pwm_axil_slave.sv
// tb_myip_pwm_axil_slave: scoreboard bench for the AXI4-Lite PWM slave
module tb_myip_pwm_axil_slave;
  logic        clk = 0, rst_n = 0;
  logic [3:0]  awaddr = 0, araddr = 0, wstrb = 0;
  logic [2:0]  awprot = 0, arprot = 0;
  logic        awvalid = 0, wvalid = 0, bready = 1, arvalid = 0, rready = 1;
  logic [31:0] wdata = 0;
  logic        awready, wready, bvalid, arready, rvalid, pwm_out;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata;
`ifdef MYIP_PWM_IRQ_EN
  logic        irq;
`endif
  logic [1:0]  exp_b[$];
  logic [31:0] exp_r[$];
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  myip_pwm_axil_slave dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .pwm_out(pwm_out)
`ifdef MYIP_PWM_IRQ_EN
    , .irq(irq)
`endif
  );
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask
  // monitor: pop and compare on every completed response handshake
  always @(negedge clk) begin
    if (rst_n && bvalid && bready) begin
      if (exp_b.size() == 0) begin
        checks++; errors++;
        $display("FAIL b_unexpected: got bresp 0x%0h with empty queue", bresp);
      end else check("bresp", 32'(bresp), 32'(exp_b.pop_front()));
    end
    if (rst_n && rvalid && rready) begin
      check("rresp", 32'(rresp), 32'h0);
      if (exp_r.size() == 0) begin
        checks++; errors++;
        $display("FAIL r_unexpected: got rdata 0x%08h with empty queue", rdata);
      end else check("rdata", rdata, exp_r.pop_front());
    end
  end
  task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s, input int lead, input int bhold);
    int i;
    if (bhold > 0) bready = 0;
    awaddr = a; awvalid = 1;
    repeat (lead) begin
      @(negedge clk); check("aw_no_ready_without_w", 32'(awready), 32'h0);
      @(posedge clk); #1;
    end
    wdata = d; wstrb = s; wvalid = 1;
    for (i = 0; i < 20; i++) begin
      @(negedge clk);
      if (awready) break;
      @(posedge clk); #1;
    end
    if (i == 20) begin
      checks++; errors++;
      $display("FAIL aw_timeout: got no awready expected within 20 cycles");
      @(posedge clk); #1; awvalid = 0; wvalid = 0; bready = 1;
      return;
    end
    check("wready_with_awready", 32'(wready), 32'h1);
    exp_b.push_back(2'b00);
    @(posedge clk); #1; awvalid = 0; wvalid = 0;
    repeat (bhold) begin
      @(negedge clk); check("bvalid_held", 32'(bvalid), 32'h1);
      @(posedge clk); #1;
    end
    bready = 1;
    for (i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bvalid) break;
    end
    if (i == 20) begin
      checks++; errors++;
      $display("FAIL b_timeout: got no bvalid expected within 20 cycles");
    end
    @(posedge clk); #1;
  endtask
  task automatic rd(input logic [3:0] a, input logic [31:0] exp, input int rhold);
    int i;
    if (rhold > 0) rready = 0;
    araddr = a; arvalid = 1;
    for (i = 0; i < 20; i++) begin
      @(negedge clk);
      if (arready) break;
      @(posedge clk); #1;
    end
    if (i == 20) begin
      checks++; errors++;
      $display("FAIL ar_timeout: got no arready expected within 20 cycles");
      @(posedge clk); #1; arvalid = 0; rready = 1;
      return;
    end
    exp_r.push_back(exp);
    @(posedge clk); #1; arvalid = 0;
    repeat (rhold) begin
      @(negedge clk);
      check("rvalid_held", 32'(rvalid), 32'h1);
      check("rdata_stable", rdata, exp);
      @(posedge clk); #1;
    end
    rready = 1;
    for (i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rvalid) break;
    end
    if (i == 20) begin
      checks++; errors++;
      $display("FAIL r_timeout: got no rvalid expected within 20 cycles");
    end
    @(posedge clk); #1;
  endtask
  task automatic pwm_shape(input int eh, input int el, input string name);
    int i, h, l;
    i = 0; h = 0; l = 0;
    @(negedge clk);
    while (pwm_out !== 1'b0 && i < 100) begin @(negedge clk); i++; end
    while (pwm_out !== 1'b1 && i < 200) begin @(negedge clk); i++; end
    while (pwm_out === 1'b1 && h < 100) begin h++; @(negedge clk); end
    while (pwm_out === 1'b0 && l < 100) begin l++; @(negedge clk); end
    check({name, "_high"}, h, eh);
    check({name, "_low"}, l, el);
    @(posedge clk); #1;
  endtask
  task automatic pwm_const(input int exp_high, input string name);
    int h;
    h = 0;
    repeat (40) @(posedge clk);
    repeat (30) begin @(negedge clk); if (pwm_out === 1'b1) h++; end
    check(name, h, exp_high);
    @(posedge clk); #1;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected before 200us");
    $fatal(1);
  end
  initial begin
    int i;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_awready", 32'(awready), 0);
    check("rst_wready", 32'(wready), 0);
    check("rst_bvalid", 32'(bvalid), 0);
    check("rst_arready", 32'(arready), 0);
    check("rst_rvalid", 32'(rvalid), 0);
    check("rst_rdata", rdata, 0);
    check("rst_pwm", 32'(pwm_out), 0);
    @(posedge clk); #1; rst_n = 1;
    @(posedge clk); #1;
    for (int r = 0; r < 4; r++) rd(4'(r * 4), 32'h0, 0);
    wr(4'h0, 32'h1, 4'hf, 0, 0);
    wr(4'h4, 32'h2, 4'hf, 0, 0);
    wr(4'h8, 32'h3, 4'hf, 0, 0);
    wr(4'hc, 32'h4, 4'hf, 0, 0);
    rd(4'h0, 32'h1, 0);
    rd(4'h4, 32'h2, 0);
    rd(4'h8, 32'h3, 0);
    rd(4'hc, 32'h4, 0);
    wr(4'h8, 32'h0, 4'hf, 0, 0);
    wr(4'h8, 32'hffffffff, 4'b0101, 0, 0);
    rd(4'h8, 32'h00ff00ff, 0);
    wr(4'h4, 32'h1234, 4'hf, 5, 3);
    rd(4'h4, 32'h1234, 3);
    rd(4'h5, 32'h1234, 0);
    wr(4'h0, 32'h0, 4'hf, 0, 0);
    wr(4'h4, 32'd9, 4'hf, 0, 0);
    wr(4'h8, 32'd3, 4'hf, 0, 0);
    wr(4'hc, 32'd0, 4'hf, 0, 0);
    wr(4'h0, 32'h1, 4'hf, 0, 0);
    pwm_shape(3, 7, "p9d3");
    pwm_shape(3, 7, "p9d3_repeat");
    wr(4'h0, 32'h0, 4'hf, 0, 0);
    wr(4'h4, 32'd4, 4'hf, 0, 0);
    wr(4'h8, 32'd2, 4'hf, 0, 0);
    wr(4'hc, 32'd1, 4'hf, 0, 0);
    wr(4'h0, 32'h1, 4'hf, 0, 0);
    pwm_shape(4, 6, "p4d2s1");
    wr(4'h8, 32'd0, 4'hf, 0, 0);
    pwm_const(0, "duty0_low");
    wr(4'h8, 32'd7, 4'hf, 0, 0);
    pwm_const(30, "duty7_high");
    bready = 0;
    awaddr = 4'h8; wdata = 32'h5; wstrb = 4'hf; awvalid = 1; wvalid = 1;
    for (i = 0; i < 20; i++) begin
      @(negedge clk);
      if (awready) break;
      @(posedge clk); #1;
    end
    @(posedge clk); #1; awvalid = 0; wvalid = 0;
    @(negedge clk);
    check("pre_reset_bvalid", 32'(bvalid), 1);
    check("pre_reset_pwm", 32'(pwm_out), 1);
    @(posedge clk); #1; rst_n = 0;
    @(posedge clk); #1; rst_n = 1;
    @(negedge clk);
    check("post_reset_bvalid", 32'(bvalid), 0);
    check("post_reset_pwm", 32'(pwm_out), 0);
    @(posedge clk); #1; bready = 1;
    for (int r = 0; r < 4; r++) rd(4'(r * 4), 32'h0, 0);
    check("scoreboard_drained", 32'(exp_b.size() + exp_r.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
